// File: rtl/int_ctrl_if.sv
// Purpose : bundles the interrupt controller's source, CPU handshake and status signals.
// Latency : n/a (wiring only).
// Backpressure: none. The CPU holds int_req pending until it pulses int_ack.
// Ports   : irq_in/mask_wr/mask_din/int_ack/eoi flow master->slave (toward the controller);
//           int_req/int_num/mask/pending/in_service flow slave->master (from the controller).
interface int_ctrl_if #(
    parameter int N_CH = 8
);
    logic [N_CH-1:0] irq_in;
    logic            mask_wr;
    logic [N_CH-1:0] mask_din;
    logic            int_ack;
    logic            eoi;
    logic            int_req;
    logic [31:0]     int_num;
    logic [N_CH-1:0] mask;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] in_service;

    // Driven by the CPU / interrupt sources.
    modport master (
        output irq_in, mask_wr, mask_din, int_ack, eoi,
        input  int_req, int_num, mask, pending, in_service
    );

    // Implemented by the controller.
    modport slave (
        input  irq_in, mask_wr, mask_din, int_ack, eoi,
        output int_req, int_num, mask, pending, in_service
    );
endinterface

// File: rtl/int_ctrl.sv
// Purpose : fixed-priority interrupt controller (lowest channel wins) with a mask, pending
//           latching, and a single non-nesting service slot.
// Latency : a trigger at edge t is pending at t. int_req rises after edge t+1 (from IDLE).
// Backpressure: int_req and int_num hold steady until int_ack. No new request starts until eoi.
// Ports   : clk, rst (synchronous, active-high). bus (int_ctrl_if.slave) carries the
//           irq_in sources, the mask write, the int_ack/eoi handshake and all registered outputs.
// Config  : INTC_EDGE_EN defined   -> rising-edge triggered channels (per-channel history).
//           INTC_EDGE_EN undefined -> level triggered channels.
module int_ctrl #(
    parameter int          N_CH     = 8,
    parameter logic [31:0] BASE_NUM = 32'h10
) (
    input logic       clk,
    input logic       rst,
    int_ctrl_if.slave bus
);

    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t            state_q;
    logic [N_CH-1:0]   pending_q;
    logic [N_CH-1:0]   mask_q;
    logic [N_CH-1:0]   in_service_q;
    logic              int_req_q;
    logic [31:0]       int_num_q;
    logic [SEL_W-1:0]  sel_q;

    logic [N_CH-1:0]   trig;
    logic [N_CH-1:0]   arb_vec;
    logic [N_CH-1:0]   sel_oh;
    logic [N_CH-1:0]   pending_d;
    logic [SEL_W-1:0]  sel_d;
    logic              arb_hit;

`ifdef INTC_EDGE_EN
    // The history register holds last cycle's line level. A steady high line triggers once.
    logic [N_CH-1:0]   hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= bus.irq_in;
        end
    end

    assign trig = bus.irq_in & ~hist_q;
`else
    assign trig = bus.irq_in;
`endif

    // Arbitration uses registered pending and mask. A mask write this cycle only counts next edge.
    assign arb_vec = pending_q & ~mask_q;

    // The loop runs high to low, so the last hit it records is the lowest index.
    always_comb begin
        sel_d   = '0;
        arb_hit = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (arb_vec[i]) begin
                sel_d   = SEL_W'(i);
                arb_hit = 1'b1;
            end
        end
    end

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel_oh[i] = (sel_q == SEL_W'(i));
        end
    end

    // The ack clear is applied first and the trigger is ORed in after it.
    // If a new trigger coincides with the ack, the pending bit stays set.
    always_comb begin
        pending_d = pending_q;
        if ((state_q == REQ) && bus.int_ack) begin
            pending_d = pending_d & ~sel_oh;
        end
        pending_d = pending_d | trig;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            mask_q       <= '1;
            in_service_q <= '0;
            int_req_q    <= 1'b0;
            int_num_q    <= '0;
            sel_q        <= '0;
        end else begin
            pending_q <= pending_d;
            if (bus.mask_wr) begin
                mask_q <= bus.mask_din;
            end
            case (state_q)
                IDLE: begin
                    if (arb_hit) begin
                        sel_q     <= sel_d;
                        int_req_q <= 1'b1;
                        int_num_q <= BASE_NUM + {{(32 - SEL_W){1'b0}}, sel_d};
                        state_q   <= REQ;
                    end
                end
                // sel_q and int_num_q are frozen here. A request is never withdrawn or re-targeted.
                REQ: begin
                    if (bus.int_ack) begin
                        in_service_q <= sel_oh;
                        int_req_q    <= 1'b0;
                        state_q      <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (bus.eoi) begin
                        in_service_q <= '0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.int_req    = int_req_q;
    assign bus.int_num    = int_num_q;
    assign bus.mask       = mask_q;
    assign bus.pending    = pending_q;
    assign bus.in_service = in_service_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Purpose : self-checking bench for int_ctrl. It runs directed scenarios, then random traffic
//           checked against a behavioural model.
// Latency : the model is stepped at every rising edge. Outputs are compared 1 ns later.
// Backpressure: the bench plays the CPU and acks or eois based on the observed int_req/in_service.
module tb_int_ctrl;

    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'h10;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int_ctrl_if #(.N_CH(N)) bus ();

    int_ctrl #(
        .N_CH     (N),
        .BASE_NUM (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model. phase: 0 = waiting, 1 = requesting, 2 = being serviced.
    bit [N-1:0] m_pend;
    bit [N-1:0] m_mask;
    bit [N-1:0] m_insvc;
    bit [N-1:0] m_hist;
    bit         m_req;
    bit [31:0]  m_num;
    int         m_phase;
    int         m_sel;

    function automatic int lowest(input bit [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_update();
        bit [N-1:0] trig;
        int         w;
`ifdef INTC_EDGE_EN
        trig = bus.irq_in & ~m_hist;
`else
        trig = bus.irq_in;
`endif
        if (rst) begin
            m_pend  = '0;
            m_mask  = '1;
            m_insvc = '0;
            m_hist  = '0;
            m_req   = 1'b0;
            m_num   = 32'd0;
            m_phase = 0;
            m_sel   = 0;
            return;
        end
        case (m_phase)
            0: begin
                w = lowest(m_pend & ~m_mask);
                if (w >= 0) begin
                    m_sel   = w;
                    m_req   = 1'b1;
                    m_num   = BASE + 32'(w);
                    m_phase = 1;
                end
            end
            1: begin
                if (bus.int_ack) begin
                    m_pend[m_sel]  = 1'b0;
                    m_insvc        = '0;
                    m_insvc[m_sel] = 1'b1;
                    m_req          = 1'b0;
                    m_phase        = 2;
                end
            end
            default: begin
                if (bus.eoi) begin
                    m_insvc = '0;
                    m_phase = 0;
                end
            end
        endcase
        m_pend = m_pend | trig;
        if (bus.mask_wr) m_mask = bus.mask_din;
        m_hist = bus.irq_in;
    endfunction

    task automatic compare_all();
        check("int_req",    32'(bus.int_req),    32'(m_req));
        check("int_num",    bus.int_num,         m_num);
        check("mask",       32'(bus.mask),       32'(m_mask));
        check("pending",    32'(bus.pending),    32'(m_pend));
        check("in_service", 32'(bus.in_service), 32'(m_insvc));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic cyc(input logic [N-1:0] irq, input logic mw, input logic [N-1:0] md,
                       input logic ack, input logic e);
        rst          = 1'b0;
        bus.irq_in   = irq;
        bus.mask_wr  = mw;
        bus.mask_din = md;
        bus.int_ack  = ack;
        bus.eoi      = e;
        step();
    endtask

    task automatic cyc_rst();
        rst          = 1'b1;
        bus.irq_in   = '0;
        bus.mask_wr  = 1'b0;
        bus.mask_din = '0;
        bus.int_ack  = 1'b0;
        bus.eoi      = 1'b0;
        step();
    endtask

    // The bench acts as the CPU. It acks a visible request and ends a visible service.
    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            cyc('0, 1'b0, '0, bus.int_req, bus.in_service != '0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          rises;
        logic        prev_req;
        logic [N-1:0] r_irq;

        rst          = 1'b1;
        bus.irq_in   = '0;
        bus.mask_wr  = 1'b0;
        bus.mask_din = '0;
        bus.int_ack  = 1'b0;
        bus.eoi      = 1'b0;

        cyc_rst();
        cyc_rst();
        check("rst_mask",    32'(bus.mask),       32'h0000_00FF);
        check("rst_int_num", bus.int_num,         32'h0);
        check("rst_int_req", 32'(bus.int_req),    32'h0);
        check("rst_pending", 32'(bus.pending),    32'h0);

        // Channel 0 unmasked while pulsing.
        cyc(8'h01, 1'b1, 8'hFE, 1'b0, 1'b0);
        check("c33_pending", 32'(bus.pending), 32'h01);
        check("c33_req_early", 32'(bus.int_req), 32'h0);
        cyc('0, 1'b0, '0, 1'b0, 1'b0);
        check("c33_req", 32'(bus.int_req), 32'h1);
        check("c33_num", bus.int_num, 32'h10);
        cyc('0, 1'b0, '0, 1'b1, 1'b0);
        check("c33_insvc", 32'(bus.in_service), 32'h01);
        cyc('0, 1'b0, '0, 1'b0, 1'b1);

        // Two channels at once. Lowest index first, then the other after eoi.
        cyc('0, 1'b1, 8'h00, 1'b0, 1'b0);
        cyc(8'h28, 1'b0, '0, 1'b0, 1'b0);
        cyc('0, 1'b0, '0, 1'b0, 1'b0);
        check("c34_num_a", bus.int_num, 32'h13);
        cyc('0, 1'b0, '0, 1'b1, 1'b0);
        cyc('0, 1'b0, '0, 1'b0, 1'b1);
        cyc('0, 1'b0, '0, 1'b0, 1'b0);
        check("c34_req_b", 32'(bus.int_req), 32'h1);
        check("c34_num_b", bus.int_num, 32'h15);
        drain(4);

        // A request in flight survives masking and a higher-priority arrival.
        cyc(8'h04, 1'b0, '0, 1'b0, 1'b0);
        cyc('0, 1'b0, '0, 1'b0, 1'b0);
        check("c35_num0", bus.int_num, 32'h12);
        cyc('0, 1'b1, 8'hFF, 1'b0, 1'b0);
        check("c35_req1", 32'(bus.int_req), 32'h1);
        cyc(8'h02, 1'b0, '0, 1'b0, 1'b0);
        cyc('0, 1'b0, '0, 1'b0, 1'b0);
        check("c35_num2", bus.int_num, 32'h12);
        cyc('0, 1'b0, '0, 1'b1, 1'b0);
        check("c35_acked", 32'(bus.in_service), 32'h04);
        cyc('0, 1'b0, '0, 1'b0, 1'b1);
        cyc('0, 1'b0, '0, 1'b0, 1'b0);
        check("c35_masked_wait", 32'(bus.int_req), 32'h0);
        cyc('0, 1'b1, 8'h00, 1'b0, 1'b0);
        drain(6);

        // Held line. Edge mode gives one request, level mode re-requests after eoi.
        rises    = 0;
        prev_req = bus.int_req;
        for (int k = 0; k < 10; k++) begin
            cyc(8'h02, 1'b0, '0, bus.int_req, bus.in_service != '0);
            if (bus.int_req && !prev_req) rises++;
            prev_req = bus.int_req;
        end
        for (int k = 0; k < 8; k++) begin
            cyc('0, 1'b0, '0, bus.int_req, bus.in_service != '0);
            if (bus.int_req && !prev_req) rises++;
            prev_req = bus.int_req;
        end
`ifdef INTC_EDGE_EN
        check("c36_requests", 32'(rises), 32'd1);
`else
        check("c36_multi_req", 32'(rises >= 2), 32'd1);
`endif
        drain(4);

        // Stray handshakes are ignored.
        cyc('0, 1'b0, '0, 1'b1, 1'b0);
        check("c38_idle_ack_req", 32'(bus.int_req), 32'h0);
        check("c38_idle_ack_pend", 32'(bus.pending), 32'h0);
        cyc(8'h08, 1'b0, '0, 1'b0, 1'b0);
        cyc('0, 1'b0, '0, 1'b0, 1'b0);
        cyc('0, 1'b0, '0, 1'b0, 1'b1);
        check("c38_req_eoi", 32'(bus.int_req), 32'h1);
        check("c38_req_eoi_pend", 32'(bus.pending), 32'h08);
        cyc('0, 1'b0, '0, 1'b1, 1'b0);
        cyc('0, 1'b0, '0, 1'b1, 1'b0);
        check("c38_svc_ack", 32'(bus.in_service), 32'h08);
        cyc('0, 1'b0, '0, 1'b0, 1'b1);

        // Reset during service.
        cyc(8'h10, 1'b0, '0, 1'b0, 1'b0);
        cyc('0, 1'b0, '0, 1'b0, 1'b0);
        cyc('0, 1'b0, '0, 1'b1, 1'b0);
        check("c37_in_svc", 32'(bus.in_service), 32'h10);
        cyc_rst();
        check("c37_insvc0", 32'(bus.in_service), 32'h0);
        check("c37_mask",   32'(bus.mask),       32'hFF);
        check("c37_req",    32'(bus.int_req),    32'h0);
        cyc('0, 1'b0, '0, 1'b0, 1'b1);
        check("c37_eoi_req",   32'(bus.int_req),    32'h0);
        check("c37_eoi_insvc", 32'(bus.in_service), 32'h0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                cyc_rst();
            end else begin
                r_irq = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
                cyc(r_irq,
                    $urandom_range(0, 19) == 0,
                    N'($urandom),
                    bus.int_req ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 29) == 0),
                    (bus.in_service != '0) ? ($urandom_range(0, 1) == 1)
                                           : ($urandom_range(0, 29) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
